eru_varlat_adder: RTL and testbench
===================================

// Module: eru_varlat_adder
// PURPOSE
// - Parametrised block-based speculative-carry adder with error-reduction (ERU) carry select.
// - Adds a variable-latency exact-recovery path behind a valid/ready handshake.
// - Approximate mode: the speculative sum is returned after 1 cycle.
// - Exact mode: a mis-speculated sum is corrected in one extra RECOVER cycle.
// - Sits as the adder leaf in accuracy-configurable datapaths; mode is selectable per operation.
// PARAMETERS
// - WIDTH  16  operand width; must be a multiple of BLK and >= 2*BLK
// - BLK    4   block (sub-adder) width; NB = WIDTH/BLK blocks
// - CNT_W  16  error-counter width (used only with ERU_ERRCNT_EN)
// PORTS
// - clk        in   1        clock, rising edge
// - rst_n      in   1        asynchronous active-low reset
// - in_valid   in   1        operands valid
// - in_ready   out  1        block can accept operands
// - a, b       in   WIDTH    operands (unsigned)
// - exact_md   in   1        1 = exact mode (recover on error); 0 = approximate; sampled with operands
// - out_valid  out  1        result valid
// - out_ready  in   1        consumer accepts result
// - sum        out  WIDTH+1  result, MSB = carry out
// - out_err    out  1        delivered sum differs from a+b (approximate mode only)
// - out_fixed  out  1        delivered sum was corrected via RECOVER
// - cnt_clr    in   1        sync clear of err_cnt          [ERU_ERRCNT_EN only]
// - err_cnt    out  CNT_W    count of mis-speculated operations [ERU_ERRCNT_EN only]
// BEHAVIOUR
// - Operand terms: p = a^b, g = a&b.
// - Speculation for block k, k = 1..NB-1, L = k*BLK:
//   - cadd_k = carry out of bits [L-1 : max(L-BLK-1, 0)], carry-in 0.
//   - sel_k  = g[L-1] | (~a[L] & ~b[L]).
//   - cin_k  = sel_k ? g[L-1] : cadd_k.
//   - Block 0 uses cin = 0.
// - Block sum: exact BLK-bit add of p/g with cin_k.
//   - LSB correction for k >= 1: sum[L] = (p[L]^cin_k) | (~p[L] & ~g[L] & cadd_k).
//   - sum[WIDTH] = carry out of block NB-1 using its cin.
// - Error flag: spec_err = (approx_sum != a+b), computed at accept on the WIDTH+1-bit value.
// - Handshake: accept on in_valid & in_ready; hold on out_valid & !out_ready.
// - On hold, sum, out_err and out_fixed are stable, and in_ready = 0.
// - FSM states IDLE, RECOVER, VALID:
//   - IDLE:    in_ready = 1, out_valid = 0.
//     - Accept with exact_md & spec_err -> RECOVER; otherwise register approx_sum -> VALID.
//   - RECOVER: in_ready = 0, out_valid = 0; exactly one cycle.
//     - Registers exact a+b (from the held operand registers) -> VALID, out_fixed = 1, out_err = 0.
//   - VALID:   out_valid = 1, in_ready = out_ready.
//     - out_ready & in_valid: back-to-back accept, same rules as IDLE.
//     - out_ready & !in_valid -> IDLE.
//     - !out_ready -> stay.
// - out_err = spec_err & !exact_md; out_fixed = spec_err & exact_md.
// - Latency from accept edge N:
//   - out_valid at N+1 when there is no error or in approximate mode.
//   - out_valid at N+2 when recovered.
//   - Throughput: 1/cycle, or 1 per 2 cycles on recovery.
// - Reset (async, any state, including mid-RECOVER):
//   - state = IDLE, sum = 0, out_valid = 0, out_err = 0, out_fixed = 0, err_cnt = 0.
//   - In-flight operation is discarded.
//   - in_ready = 1 from the first edge after release.
// CONFIGURATION
// - ERU_ERRCNT_EN defined:
//   - cnt_clr and err_cnt ports exist.
//   - err_cnt increments on every accept with spec_err, in either mode, and saturates at 2^CNT_W-1.
//   - cnt_clr has priority over an increment in the same cycle.
// - Undefined: ports and counter logic are absent; all other behaviour is identical.
// TESTING (WIDTH=16, BLK=4)
// - a=0x000F, b=0x0001, exact_md=0 -> sum=0x00010, out_err=0 (LSB correction), out_valid at N+1.
// - a=0x00FF, b=0x0001, exact_md=0 -> sum=0x00000, out_err=1, out_fixed=0, out_valid at N+1.
// - a=0x00FF, b=0x0001, exact_md=1 -> sum=0x00100, out_fixed=1, out_valid at N+2;
//   in_ready=0 during RECOVER.
// - a=0xFFFF, b=0x0001, exact_md=1 with out_ready=0 for 3 cycles -> sum=0x10000 held stable,
//   in_ready=0 until release.
// - Stream 8 error-free ops with in_valid=out_ready=1 -> one result per cycle, in order, no bubbles;
//   rst_n low during RECOVER -> outputs 0, IDLE.
// - ERU_ERRCNT_EN: 3 erroring ops (mixed modes) -> err_cnt=3;
//   cnt_clr plus an erroring accept in the same cycle -> err_cnt=0.

Source files
------------

// File: rtl/eru_varlat_adder.sv
// ============================================================================
// Module   : eru_varlat_adder
// Brief    : Block-speculative adder with ERU carry select and a one-cycle
//            exact-recovery path behind a valid/ready handshake.
//            Optional error counter enabled by defining ERU_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eru_varlat_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             exact_md,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             out_err,
    output logic             out_fixed
`ifdef ERU_ERRCNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int NB = WIDTH / BLK;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECOVER = 2'd1,
        VALID   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH:0]   w_approx;
    logic [WIDTH:0]   w_exact;
    logic [WIDTH:0]   w_recov;
    logic             w_spec_err;
    logic             w_accept;
    logic             w_go_recover;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   r_sum;
    logic             r_err;
    logic             r_fixed;

    // Speculative sum: each block guesses its carry-in from a short window
    // below it; the ERU select uses the exact carry when it is locally known.
    generate
        for (genvar k = 0; k < NB; k++) begin : g_blk
            if (k == 0) begin : g_first
                assign w_approx[BLK-1:0] = a[BLK-1:0] + b[BLK-1:0];
            end else begin : g_spec
                localparam int L  = k * BLK;
                localparam int LO = (L - BLK - 1 < 0) ? 0 : L - BLK - 1;
                logic w_cadd;
                logic w_sel;
                logic w_cin;
                logic w_kill;

                // Carry out of x+y over n bits is (x > ~y).
                assign w_cadd = (a[L-1:LO] > ~b[L-1:LO]);
                assign w_kill = ~a[L] & ~b[L];
                assign w_sel  = (a[L-1] & b[L-1]) | w_kill;
                assign w_cin  = w_sel ? (a[L-1] & b[L-1]) : w_cadd;

                if (k == NB - 1) begin : g_last
                    logic [BLK:0] w_bs;
                    assign w_bs = {1'b0, a[WIDTH-1:L]} + {1'b0, b[WIDTH-1:L]}
                                + {{BLK{1'b0}}, w_cin};
                    assign w_approx[WIDTH:L+1] = w_bs[BLK:1];
                    assign w_approx[L]         = w_bs[0] | (w_kill & w_cadd);
                end else begin : g_mid
                    logic [BLK-1:0] w_bs;
                    assign w_bs = a[L+BLK-1:L] + b[L+BLK-1:L]
                                + {{(BLK-1){1'b0}}, w_cin};
                    assign w_approx[L+BLK-1:L+1] = w_bs[BLK-1:1];
                    assign w_approx[L]           = w_bs[0] | (w_kill & w_cadd);
                end
            end
        end
    endgenerate

    assign w_exact      = {1'b0, a} + {1'b0, b};
    assign w_recov      = {1'b0, r_a} + {1'b0, r_b};
    assign w_spec_err   = (w_approx != w_exact);
    assign w_accept     = in_valid & in_ready;
    assign w_go_recover = exact_md & w_spec_err;

    assign in_ready  = (r_state == IDLE) | ((r_state == VALID) & out_ready);
    assign out_valid = (r_state == VALID);
    assign sum       = r_sum;
    assign out_err   = r_err;
    assign out_fixed = r_fixed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, VALID: begin
                if (w_accept) begin
                    w_next = w_go_recover ? RECOVER : VALID;
                end else if (r_state == VALID && out_ready) begin
                    w_next = IDLE;
                end
            end
            RECOVER: w_next = VALID;
            default: w_next = IDLE;
        endcase
    end

    // Operands are kept so RECOVER can rebuild the exact sum one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_err   <= 1'b0;
            r_fixed <= 1'b0;
        end else if (w_accept) begin
            r_a <= a;
            r_b <= b;
            if (!w_go_recover) begin
                r_sum   <= w_approx;
                r_err   <= w_spec_err;
                r_fixed <= 1'b0;
            end
        end else if (r_state == RECOVER) begin
            r_sum   <= w_recov;
            r_err   <= 1'b0;
            r_fixed <= 1'b1;
        end
    end

`ifdef ERU_ERRCNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (cnt_clr) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_spec_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_eru_varlat_adder.sv
// Self-checking bench for eru_varlat_adder (WIDTH=16, BLK=4): directed table,
// random ops against an arithmetic model, streaming, stall, counter and reset.
`default_nettype none

module tb_eru_varlat_adder;

    localparam int W  = 16;
    localparam int B  = 4;
    localparam int NB = W / B;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          exact_md;
    logic          out_valid;
    logic          out_ready;
    logic [W:0]    sum;
    logic          out_err;
    logic          out_fixed;
`ifdef ERU_ERRCNT_EN
    logic          cnt_clr;
    logic [15:0]   err_cnt;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    eru_varlat_adder #(.WIDTH(W), .BLK(B), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .exact_md  (exact_md),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .out_err   (out_err),
        .out_fixed (out_fixed)
`ifdef ERU_ERRCNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .err_cnt   (err_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Speculative sum straight from the block rules, using integer arithmetic.
    function automatic logic [W:0] model_approx(input logic [W-1:0] av, input logic [W-1:0] bv);
        int ai, bi, res, m, lo, wd, x, y, cadd, gl1, both0, cin, bs, L;
        ai = int'(av);
        bi = int'(bv);
        res = 0;
        m = (1 << B) - 1;
        for (int k = 0; k < NB; k++) begin
            L = k * B;
            cin = 0;
            cadd = 0;
            both0 = 0;
            if (k > 0) begin
                lo = (L - B - 1 < 0) ? 0 : L - B - 1;
                wd = L - lo;
                x = (ai >> lo) & ((1 << wd) - 1);
                y = (bi >> lo) & ((1 << wd) - 1);
                cadd = ((x + y) >> wd) & 1;
                gl1 = ((ai & bi) >> (L - 1)) & 1;
                both0 = (((ai | bi) >> L) & 1) == 0 ? 1 : 0;
                cin = (gl1 == 1 || both0 == 1) ? gl1 : cadd;
            end
            bs = ((ai >> L) & m) + ((bi >> L) & m) + cin;
            res = res | ((bs & m) << L);
            if (both0 == 1 && cadd == 1) res = res | (1 << L);
            if (k == NB - 1) res = res | ((bs >> B) << W);
        end
        return res[W:0];
    endfunction

    task automatic model_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic md,
                            output logic [W:0] es, output logic ee, output logic ef, output int el);
        logic [W:0] ap, ex;
        ap = model_approx(av, bv);
        ex = 17'(av) + 17'(bv);
        if (ap != ex && md) begin
            es = ex; ee = 1'b0; ef = 1'b1; el = 2;
        end else begin
            es = ap; ee = (ap != ex); ef = 1'b0; el = 1;
        end
    endtask

    // One op from IDLE with out_ready=1; returns outputs and accept-to-valid latency.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic md,
                          output logic [W:0] s, output logic e, output logic f, output int lat,
                          output logic rdy_mid);
        @(negedge clk);
        in_valid = 1'b1; a = av; b = bv; exact_md = md;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rdy_mid = in_ready;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        s = sum; e = out_err; f = out_fixed;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         md;
        logic [W:0]   s;
        logic         err;
        logic         fix;
        int           lat;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0] s, es;
        logic e, f, ee, ef, rm;
        int lat, el;
        logic [W-1:0] sa [8];
        logic [W-1:0] sb [8];
        logic [W:0]   ss [8];
        logic [W:0]   held;

        tbl[0] = '{16'h000F, 16'h0001, 1'b0, 17'h00010, 1'b0, 1'b0, 1};
        tbl[1] = '{16'h00FF, 16'h0001, 1'b0, 17'h00000, 1'b1, 1'b0, 1};
        tbl[2] = '{16'h00FF, 16'h0001, 1'b1, 17'h00100, 1'b0, 1'b1, 2};
        tbl[3] = '{16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0, 1'b0, 1};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFE, 1'b0, 1'b0, 1};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; exact_md = 1'b0; out_ready = 1'b1;
`ifdef ERU_ERRCNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_sum", 32'(sum), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_flags", 32'({out_err, out_fixed}), 32'h0);
`ifdef ERU_ERRCNT_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].md, s, e, f, lat, rm);
            chk($sformatf("tbl%0d_sum", i), 32'(s), 32'(tbl[i].s));
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_fixed", i), 32'(f), 32'(tbl[i].fix));
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            if (tbl[i].lat == 2) chk($sformatf("tbl%0d_ready_recover", i), 32'(rm), 32'h0);
        end

        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] ra, rb;
            logic rmd;
            ra = W'($urandom);
            rb = W'($urandom);
            rmd = 1'($urandom_range(0, 1));
            model_op(ra, rb, rmd, es, ee, ef, el);
            run_op(ra, rb, rmd, s, e, f, lat, rm);
            chk($sformatf("rnd%0d_result", i), 32'({s, e, f}), 32'({es, ee, ef}));
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(el));
        end

        // Stream of error-free ops: one result per cycle, in order.
        for (int i = 0; i < 8; i++) begin
            sa[i] = W'($urandom); sb[i] = W'($urandom);
            for (int t = 0; t < 200 && model_approx(sa[i], sb[i]) != 17'(sa[i]) + 17'(sb[i]); t++) begin
                sa[i] = W'($urandom); sb[i] = W'($urandom);
            end
            if (model_approx(sa[i], sb[i]) != 17'(sa[i]) + 17'(sb[i])) begin
                sa[i] = 16'(i); sb[i] = 16'h0100;
            end
            ss[i] = 17'(sa[i]) + 17'(sb[i]);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("stream%0d_valid", i - 1), 32'(out_valid), 32'h1);
                chk($sformatf("stream%0d_sum", i - 1), 32'(sum), 32'(ss[i - 1]));
            end
            chk($sformatf("stream%0d_ready", i), 32'(in_ready), 32'h1);
            in_valid = 1'b1; a = sa[i]; b = sb[i]; exact_md = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("stream7_valid", 32'(out_valid), 32'h1);
        chk("stream7_sum", 32'(sum), 32'(ss[7]));

        // Recovered result held under back-pressure.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; exact_md = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_recover_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        chk("hold_valid", 32'(out_valid), 32'h1);
        held = sum;
        chk("hold_sum", 32'(held), 32'h10000);
        chk("hold_fixed", 32'(out_fixed), 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_stable", i), 32'({out_valid, sum, out_fixed, out_err}),
                32'({1'b1, held, 1'b1, 1'b0}));
            chk($sformatf("hold%0d_ready", i), 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("hold_release_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        chk("hold_release_idle", 32'(out_valid), 32'h0);

`ifdef ERU_ERRCNT_EN
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        run_op(16'h00FF, 16'h0001, 1'b0, s, e, f, lat, rm);
        run_op(16'h00FF, 16'h0001, 1'b1, s, e, f, lat, rm);
        run_op(16'hFFFF, 16'h0001, 1'b0, s, e, f, lat, rm);
        chk("cnt_three", 32'(err_cnt), 32'd3);
        @(negedge clk);
        cnt_clr = 1'b1;
        in_valid = 1'b1; a = 16'h00FF; b = 16'h0001; exact_md = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cnt_clr = 1'b0;
        in_valid = 1'b0;
        chk("cnt_clr_priority", 32'(err_cnt), 32'd0);
        @(negedge clk);
`endif

        // Reset asserted mid-RECOVER discards the operation.
        @(negedge clk);
        in_valid = 1'b1; a = 16'h00FF; b = 16'h0001; exact_md = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rstrec_ready_recover", 32'(in_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rstrec_outputs", 32'({out_valid, sum, out_err, out_fixed}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstrec_ready", 32'(in_ready), 32'h1);
        chk("rstrec_idle", 32'(out_valid), 32'h0);
        run_op(16'h000F, 16'h0001, 1'b0, s, e, f, lat, rm);
        chk("rstrec_after_sum", 32'(s), 32'h10);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
